// File: rtl/vx_operand_collector.sv
// Operand collector: accepts one scoreboard-cleared instruction, reads rs1..rs3 through one GPR port, presents them to dispatch.
// Optional OPC_ZERO_SKIP_EN: x0 sources are not read and are returned as zero.
`timescale 1ns/1ps
module vx_operand_collector #(
  parameter int CORE_ID     = 0,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int NR_BITS     = 6,
  parameter int WIS_W       = 2,
  parameter int META_W      = 128
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [META_W-1:0]            in_meta,
  input  logic [WIS_W-1:0]             in_wis,
  input  logic [NR_BITS-1:0]           in_rs1,
  input  logic [NR_BITS-1:0]           in_rs2,
  input  logic [NR_BITS-1:0]           in_rs3,
  output logic                         gpr_req_valid,
  input  logic                         gpr_req_ready,
  output logic [WIS_W+NR_BITS-1:0]     gpr_req_addr,
  input  logic [NUM_THREADS*XLEN-1:0]  gpr_rsp_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [META_W-1:0]            out_meta,
  output logic [WIS_W-1:0]             out_wis,
  output logic [NUM_THREADS*XLEN-1:0]  out_rs1_data,
  output logic [NUM_THREADS*XLEN-1:0]  out_rs2_data,
  output logic [NUM_THREADS*XLEN-1:0]  out_rs3_data
);
  localparam int DW = NUM_THREADS * XLEN;
  localparam int AW = WIS_W + NR_BITS;

  // CORE_ID only tags traces; reject nonsense values at elaboration.
  if (CORE_ID < 0) begin : g_core_id_chk
    $error("vx_operand_collector: CORE_ID must be non-negative");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT} state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_req_valid;
  logic                r_rsp_pending;
  logic [1:0]          r_rsp_idx;
  logic [2:0]          r_need;
  logic [AW-1:0]       r_req_addr;
  logic [META_W-1:0]   r_meta;
  logic [WIS_W-1:0]    r_wis;
  logic [NR_BITS-1:0]  r_rs [3];
  logic [DW-1:0]       r_op [3];

  logic [2:0]          w_in_need;
  logic [1:0]          w_first_idx;
  logic [1:0]          w_cur_idx;
  logic [2:0]          w_need_left;
  logic [1:0]          w_next_idx;

  function automatic logic [1:0] lowest_idx(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  function automatic logic [2:0] idx_onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  function automatic logic [NR_BITS-1:0] pick_rs(input logic [1:0] i, input logic [NR_BITS-1:0] a,
                                                 input logic [NR_BITS-1:0] b, input logic [NR_BITS-1:0] c);
    case (i)
      2'd0:    return a;
      2'd1:    return b;
      default: return c;
    endcase
  endfunction

`ifdef OPC_ZERO_SKIP_EN
  assign w_in_need = {in_rs3 != '0, in_rs2 != '0, in_rs1 != '0};
`else
  assign w_in_need = 3'b111;
`endif

  assign w_first_idx = lowest_idx(w_in_need);
  assign w_cur_idx   = lowest_idx(r_need);
  assign w_need_left = r_need & ~idx_onehot(w_cur_idx);
  assign w_next_idx  = lowest_idx(w_need_left);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_req_valid   <= 1'b0;
      r_rsp_pending <= 1'b0;
      r_rsp_idx     <= 2'd0;
      r_need        <= 3'b000;
      r_req_addr    <= '0;
      r_meta        <= '0;
      r_wis         <= '0;
      for (int k = 0; k < 3; k++) begin
        r_rs[k] <= '0;
        r_op[k] <= '0;
      end
    end else begin
      // Response capture runs off the previous cycle's accepted request only.
      r_rsp_pending <= 1'b0;
      if (r_rsp_pending) r_op[r_rsp_idx] <= gpr_rsp_data;

      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_meta     <= in_meta;
            r_wis      <= in_wis;
            r_rs[0]    <= in_rs1;
            r_rs[1]    <= in_rs2;
            r_rs[2]    <= in_rs3;
            r_need     <= w_in_need;
            r_in_ready <= 1'b0;
            for (int k = 0; k < 3; k++) r_op[k] <= '0;
            if (w_in_need != 3'b000) begin
              r_state     <= S_FETCH;
              r_req_valid <= 1'b1;
              r_req_addr  <= {in_wis, pick_rs(w_first_idx, in_rs1, in_rs2, in_rs3)};
            end else begin
              r_state     <= S_OUT;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (gpr_req_ready) begin
            r_need        <= w_need_left;
            r_rsp_idx     <= w_cur_idx;
            r_rsp_pending <= 1'b1;
            if (w_need_left == 3'b000) begin
              r_state     <= S_DRAIN;
              r_req_valid <= 1'b0;
            end else begin
              r_req_addr <= {r_wis, r_rs[w_next_idx]};
            end
          end
        end
        S_DRAIN: begin
          if (r_rsp_pending) begin
            r_state     <= S_OUT;
            r_out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign gpr_req_valid = r_req_valid;
  assign gpr_req_addr  = r_req_addr;
  assign out_valid     = r_out_valid;
  assign out_meta      = r_meta;
  assign out_wis       = r_wis;
  assign out_rs1_data  = r_op[0];
  assign out_rs2_data  = r_op[1];
  assign out_rs3_data  = r_op[2];

endmodule

// File: tb/tb_vx_operand_collector.sv
// Self-checking bench for vx_operand_collector: GPR responder, transaction-level model, per-cycle compare, directed cases.
`timescale 1ns/1ps
module tb_vx_operand_collector;
  localparam int NT = 4, XL = 32, NRB = 6, WW = 2, MW = 128, DW = NT * XL, AW = WW + NRB;
`ifdef OPC_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [MW-1:0] in_meta = '0;
  logic [WW-1:0] in_wis = '0;
  logic [NRB-1:0] in_rs1 = '0, in_rs2 = '0, in_rs3 = '0;
  logic gpr_req_valid, gpr_req_ready = 1'b1;
  logic [AW-1:0] gpr_req_addr;
  logic [DW-1:0] gpr_rsp_data = '0;
  logic out_valid, out_ready = 1'b1;
  logic [MW-1:0] out_meta;
  logic [WW-1:0] out_wis;
  logic [DW-1:0] out_rs1_data, out_rs2_data, out_rs3_data;

  vx_operand_collector #(.CORE_ID(0), .NUM_THREADS(NT), .XLEN(XL), .NR_BITS(NRB), .WIS_W(WW), .META_W(MW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_meta(in_meta), .in_wis(in_wis),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
    .gpr_req_valid(gpr_req_valid), .gpr_req_ready(gpr_req_ready), .gpr_req_addr(gpr_req_addr),
    .gpr_rsp_data(gpr_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_meta(out_meta), .out_wis(out_wis),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rs3_data(out_rs3_data));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=absent required=present (t=%0t)", nm, $time);
  endtask

  // GPR contents: each lane holds a tag derived from the address and lane number.
  function automatic logic [DW-1:0] gpr_val(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    for (int t = 0; t < NT; t++) v[t*XL +: XL] = 32'hC0DE_0000 | (32'(a) << 4) | 32'(t);
    return v;
  endfunction

  // GPR port: data one cycle after an accepted request, garbage otherwise.
  logic fire_q = 1'b0;
  logic [AW-1:0] fire_addr = '0;
  int stall_left = 0;
  logic [AW-1:0] stall_addr = '0;
  always @(negedge clk) begin
    fire_q    = gpr_req_valid && gpr_req_ready;
    fire_addr = gpr_req_addr;
  end
  initial forever begin
    @(posedge clk);
    #1;
    gpr_rsp_data = fire_q ? gpr_val(fire_addr) : {$urandom, $urandom, $urandom, $urandom};
    if (stall_left > 0 && gpr_req_valid && gpr_req_addr == stall_addr) begin
      gpr_req_ready = 1'b0;
      stall_left--;
    end else begin
      gpr_req_ready = 1'b1;
    end
  end

  typedef struct packed {
    logic [MW-1:0] meta;
    logic [WW-1:0] wis;
    logic [DW-1:0] op1, op2, op3;
    int acc;
    int n;
  } txn_t;

  txn_t q_txn[$];
  logic [AW-1:0] q_addr[$];
  logic [AW-1:0] req_log[$];
  int req_cyc_log[$], acc_log[$], fire_log[$];
  bit seen_valid = 1'b0;
  int stalls = 0;

  always @(negedge clk) begin : cmp
    txn_t t;
    logic [NRB-1:0] rs [3];
    logic [DW-1:0] ov [3];
    logic [AW-1:0] a;
    int lat, exp_lat;
    if (!reset_n) begin
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_req_valid", 128'(gpr_req_valid), 128'(0));
      check("rst_req_addr", 128'(gpr_req_addr), 128'(0));
      check("rst_rs1", out_rs1_data, '0);
      check("rst_rs2", out_rs2_data, '0);
      check("rst_rs3", out_rs3_data, '0);
      check("rst_meta", out_meta, '0);
      q_txn.delete();
      q_addr.delete();
      seen_valid = 1'b0;
      stalls = 0;
    end else begin
      check("in_ready_vs_busy", 128'(in_ready), 128'(q_txn.size() == 0));
      if (gpr_req_valid) begin
        req_log.push_back(gpr_req_addr);
        req_cyc_log.push_back(cyc);
        if (q_addr.size() == 0) note_fail("expected_request");
        else begin
          check("req_addr", 128'(gpr_req_addr), 128'(q_addr[0]));
          if (gpr_req_ready) void'(q_addr.pop_front());
          else stalls++;
        end
      end
      if (out_valid) begin
        if (q_txn.size() == 0) note_fail("expected_txn_for_out_valid");
        else begin
          if (!seen_valid) begin
            seen_valid = 1'b1;
            lat = cyc - q_txn[0].acc;
            exp_lat = (q_txn[0].n == 0) ? 1 : 2 + q_txn[0].n + stalls;
            check_int("latency", lat, exp_lat);
          end
          check("out_meta", out_meta, q_txn[0].meta);
          check("out_wis", 128'(out_wis), 128'(q_txn[0].wis));
          check("out_rs1", out_rs1_data, q_txn[0].op1);
          check("out_rs2", out_rs2_data, q_txn[0].op2);
          check("out_rs3", out_rs3_data, q_txn[0].op3);
          check_int("reqs_done_at_out", q_addr.size(), 0);
          if (out_ready) begin
            fire_log.push_back(cyc);
            void'(q_txn.pop_front());
            seen_valid = 1'b0;
            stalls = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        rs = '{in_rs1, in_rs2, in_rs3};
        t.meta = in_meta;
        t.wis  = in_wis;
        t.acc  = cyc;
        t.n    = 0;
        for (int k = 0; k < 3; k++) begin
          a = {in_wis, rs[k]};
          if (!SKIP || rs[k] != '0) begin
            q_addr.push_back(a);
            t.n++;
            ov[k] = gpr_val(a);
          end else begin
            ov[k] = '0;
          end
        end
        t.op1 = ov[0];
        t.op2 = ov[1];
        t.op3 = ov[2];
        q_txn.push_back(t);
        acc_log.push_back(cyc);
      end
    end
  end

  task automatic issue(input logic [WW-1:0] w, input logic [NRB-1:0] r1, input logic [NRB-1:0] r2,
                       input logic [NRB-1:0] r3, input logic [MW-1:0] m);
    bit ok = 1'b0;
    in_wis = w; in_rs1 = r1; in_rs2 = r2; in_rs3 = r3; in_meta = m; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) note_fail("accept_timeout");
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int c);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) note_fail("out_valid_timeout");
    c = cyc;
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, base;
    logic [DW-1:0] s1, s2, s3;
    logic [MW-1:0] sm;
    bit ok;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Three non-zero sources, no stalls
    req_log.delete(); req_cyc_log.delete();
    issue(2'd2, 6'd5, 6'd6, 6'd7, 128'h1111);
    wait_out(c);
    check_int("t1_latency", c - acc_log[$], 5);
    check_int("t1_req_count", req_log.size(), 3);
    if (req_log.size() == 3) begin
      check("t1_addr0", 128'(req_log[0]), 128'h85);
      check("t1_addr1", 128'(req_log[1]), 128'h86);
      check("t1_addr2", 128'(req_log[2]), 128'h87);
      check_int("t1_req_cycle0", req_cyc_log[0] - acc_log[$], 1);
      check_int("t1_req_cycle2", req_cyc_log[2] - acc_log[$], 3);
    end
    check("t1_rs1", out_rs1_data, 128'hC0DE0853_C0DE0852_C0DE0851_C0DE0850);
    check("t1_rs2", out_rs2_data, 128'hC0DE0863_C0DE0862_C0DE0861_C0DE0860);
    check("t1_rs3", out_rs3_data, 128'hC0DE0873_C0DE0872_C0DE0871_C0DE0870);
    check("t1_meta", out_meta, 128'h1111);

    // rs2 request stalled for two cycles
    @(posedge clk); #1;
    req_log.delete(); req_cyc_log.delete();
    stall_addr = 8'h49; stall_left = 2;
    issue(2'd1, 6'd8, 6'd9, 6'd10, 128'h2222);
    wait_out(c);
    check_int("t2_latency", c - acc_log[$], 7);
    check_int("t2_req_count", req_log.size(), 5);
    if (req_log.size() == 5) begin
      check("t2_addr0", 128'(req_log[0]), 128'h48);
      check("t2_addr1", 128'(req_log[1]), 128'h49);
      check("t2_addr3", 128'(req_log[3]), 128'h49);
      check("t2_addr4", 128'(req_log[4]), 128'h4A);
    end
    check("t2_rs2", out_rs2_data, 128'hC0DE0493_C0DE0492_C0DE0491_C0DE0490);
    check("t2_rs3", out_rs3_data, 128'hC0DE04A3_C0DE04A2_C0DE04A1_C0DE04A0);

    // All sources x0
    @(posedge clk); #1;
    req_log.delete(); req_cyc_log.delete();
    issue(2'd3, 6'd0, 6'd0, 6'd0, 128'h3333);
    wait_out(c);
    check_int("t3_latency", c - acc_log[$], SKIP ? 1 : 5);
    check_int("t3_req_count", req_log.size(), SKIP ? 0 : 3);
    foreach (req_log[i]) check("t3_addr", 128'(req_log[i]), 128'hC0);
    check("t3_rs1", out_rs1_data, SKIP ? '0 : gpr_val(8'hC0));
    check("t3_rs3", out_rs3_data, SKIP ? '0 : gpr_val(8'hC0));

    // Dispatch back-pressure for four cycles while a new instruction waits
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(2'd0, 6'd1, 6'd2, 6'd3, 128'h4444);
    wait_out(c);
    s1 = out_rs1_data; s2 = out_rs2_data; s3 = out_rs3_data; sm = out_meta;
    in_wis = 2'd1; in_rs1 = 6'd4; in_rs2 = 6'd5; in_rs3 = 6'd6; in_meta = 128'h5555; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t4_hold_rs1", out_rs1_data, s1);
      check("t4_hold_rs2", out_rs2_data, s2);
      check("t4_hold_rs3", out_rs3_data, s3);
      check("t4_hold_meta", out_meta, sm);
      check("t4_hold_valid", 128'(out_valid), 128'(1));
      check("t4_hold_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) note_fail("t4_accept");
    @(posedge clk); #1 in_valid = 1'b0;
    check_int("t4_accept_after_fire", acc_log[$] - fire_log[$], 1);
    check("t4_first_rs1", s1, 128'hC0DE0013_C0DE0012_C0DE0011_C0DE0010);
    wait_out(c);
    check("t4_second_meta", out_meta, 128'h5555);

    // Asynchronous reset one cycle after the rs2 request
    @(posedge clk); #1;
    issue(2'd2, 6'd11, 6'd12, 6'd13, 128'h6666);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("t5_in_ready", 128'(in_ready), 128'(1));
    check("t5_req_valid", 128'(gpr_req_valid), 128'(0));
    check("t5_req_addr", 128'(gpr_req_addr), 128'(0));
    check("t5_rs1", out_rs1_data, '0);
    check("t5_meta", out_meta, '0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("t5_rs2_after", out_rs2_data, '0);
    check("t5_valid_after", 128'(out_valid), 128'(0));
    issue(2'd3, 6'd14, 6'd15, 6'd16, 128'h7777);
    wait_out(c);
    check_int("t5_fresh_latency", c - acc_log[$], 5);
    check("t5_fresh_rs3", out_rs3_data, 128'hC0DE0D03_C0DE0D02_C0DE0D01_C0DE0D00);

    // Back-to-back single-source instructions
    @(posedge clk); #1;
    base = acc_log.size();
    in_wis = 2'd1; in_rs1 = 6'd1; in_rs2 = 6'd0; in_rs3 = 6'd0; in_meta = 128'h8888; in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (acc_log.size() >= base + 3) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    if (!ok) note_fail("t6_three_accepts");
    else begin
      check_int("t6_interval1", acc_log[base+1] - acc_log[base], SKIP ? 4 : 6);
      check_int("t6_interval2", acc_log[base+2] - acc_log[base+1], SKIP ? 4 : 6);
    end
    wait_out(c);
    check("t6_rs1", out_rs1_data, 128'hC0DE0413_C0DE0412_C0DE0411_C0DE0410);
    check("t6_rs2", out_rs2_data, SKIP ? '0 : gpr_val(8'h40));
    check("t6_rs3", out_rs3_data, SKIP ? '0 : gpr_val(8'h40));

    repeat (3) @(posedge clk);
    #1;
    check_int("end_model_empty", q_txn.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
